procedural_blocks_pipe: RTL and testbench

PROCEDURAL_BLOCKS_PIPE -- requirements
Module: procedural_blocks_pipe

---
 rtl/procedural_blocks_pkg.sv | 16 +
 rtl/procedural_blocks_pipe_if.sv | 28 ++
 rtl/procedural_pipe_stage.sv | 31 +++
 rtl/procedural_blocks_pipe.sv | 86 ++++++++
 tb/tb_procedural_blocks_pipe.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/procedural_blocks_pkg.sv
// Shared types and default sizes for the elastic bitwise-op pipeline.
// Imported by the interface, the stage and the top.
package procedural_blocks_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/procedural_blocks_pipe_if.sv
// Valid/ready handshake bundle: operands in, pipelined result out.
// master drives the operands and out_ready, slave is the pipeline.
interface procedural_blocks_pipe_if
  import procedural_blocks_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y_ff;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y_ff
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y_ff
  );

endinterface

// File: rtl/procedural_pipe_stage.sv
// One elastic pipeline slot: valid bit plus data register.
// Advances when empty or when the downstream slot advances.
module procedural_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_adv,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic adv;

  assign adv = !valid || down_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (adv) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/procedural_blocks_pipe.sv
// Bitwise-op unit with a combinational result, an enable-gated
// hold copy and a DEPTH-deep elastic pipeline with result counter.
module procedural_blocks_pipe
  import procedural_blocks_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  procedural_blocks_pipe_if.slave  bus,
  input  logic                     hold_en,
  output logic [WIDTH-1:0]         y_comb,
  output logic [WIDTH-1:0]         y_hold,
  output logic [CNT_W-1:0]         res_cnt
);

  logic [DEPTH:0]   adv;
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  always_comb begin
    y_comb = '0;
    unique case (bus.op)
      OP_AND:  y_comb = bus.a & bus.b;
      OP_OR:   y_comb = bus.a | bus.b;
      OP_XOR:  y_comb = bus.a ^ bus.b;
      OP_NAND: y_comb = ~(bus.a & bus.b);
      default: y_comb = '0;
    endcase
  end

  // Closed form of the advance chain: a slot moves if the sink
  // is ready or any slot at or after it is empty.
  assign adv[DEPTH] = bus.out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;

    assign adv[k] = bus.out_ready | ~(&vld[DEPTH-1:k]);

    if (k == 0) begin : g_head
      assign up_v = bus.in_valid;
      assign up_d = y_comb;
    end else begin : g_body
      assign up_v = vld[k-1];
      assign up_d = dat[k-1];
    end

    procedural_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_v),
      .up_data  (up_d),
      .down_adv (adv[k+1]),
      .valid    (vld[k]),
      .data     (dat[k])
    );
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld[DEPTH-1];
  assign bus.y_ff      = dat[DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_hold <= '0;
    end else if (hold_en) begin
      y_hold <= y_comb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready
                 && (res_cnt != {CNT_W{1'b1}})) begin
      res_cnt <= res_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_procedural_blocks_pipe.sv
// Bench for procedural_blocks_pipe: vector table, directed
// sequences and a random stream against a queue-based model.
module tb_procedural_blocks_pipe;
  import procedural_blocks_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic hold_en;

  logic [7:0]  y_comb, y_hold;
  logic [15:0] res_cnt;
  logic [7:0]  s_ycomb, s_hold;
  logic [1:0]  s_cnt;

  procedural_blocks_pipe_if #(.WIDTH(8)) bus ();
  procedural_blocks_pipe_if #(.WIDTH(8)) sbus ();

  procedural_blocks_pipe #(
    .WIDTH (8),
    .DEPTH (DEPTH),
    .CNT_W (16)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .hold_en (hold_en),
    .y_comb  (y_comb),
    .y_hold  (y_hold),
    .res_cnt (res_cnt)
  );

  procedural_blocks_pipe #(
    .WIDTH (8),
    .DEPTH (DEPTH),
    .CNT_W (2)
  ) u_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (sbus),
    .hold_en (hold_en),
    .y_comb  (s_ycomb),
    .y_hold  (s_hold),
    .res_cnt (s_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_e        op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    int         age;
  } item_t;

  int          total = 0;
  int          bad = 0;
  item_t       q[$];
  logic [7:0]  got[$];
  logic [7:0]  m_hold = 8'h00;
  logic [15:0] m_cnt = 16'h0000;
  vec_t        tbl[8];

  function automatic logic [7:0] ref_op(op_e o, logic [7:0] x,
                                        logic [7:0] y);
    case (o)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: items in order with their age in edges since acceptance;
  // the head is visible once it has aged DEPTH edges.
  task automatic cycle();
    logic       mr, mv, xi, xo, he;
    logic [7:0] nd;
    item_t      it;
    #1;
    mr = (q.size() < DEPTH) || bus.out_ready;
    mv = (q.size() > 0) && (q[0].age >= DEPTH);
    nd = ref_op(bus.op, bus.a, bus.b);
    chk("y_comb", 32'(y_comb), 32'(nd));
    chk("in_ready", 32'(bus.in_ready), 32'(mr));
    chk("out_valid", 32'(bus.out_valid), 32'(mv));
    if (mv) chk("y_ff", 32'(bus.y_ff), 32'(q[0].d));
    chk("y_hold", 32'(y_hold), 32'(m_hold));
    chk("res_cnt", 32'(res_cnt), 32'(m_cnt));
    xi = bus.in_valid && mr;
    xo = mv && bus.out_ready;
    he = hold_en;
    @(posedge clk);
    if (xo) begin
      got.push_back(q[0].d);
      void'(q.pop_front());
      if (m_cnt != 16'hFFFF) m_cnt++;
    end
    foreach (q[i]) q[i].age++;
    if (xi) begin
      it.d = nd;
      it.age = 1;
      q.push_back(it);
    end
    if (he) m_hold = nd;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] seq;
    int          dlv;
    int          sat_exp[5];
    logic        sov;

    tbl[0] = '{OP_AND,  8'hF0, 8'h3C, 8'h30};
    tbl[1] = '{OP_OR,   8'hF0, 8'h3C, 8'hFC};
    tbl[2] = '{OP_XOR,  8'hF0, 8'h3C, 8'hCC};
    tbl[3] = '{OP_NAND, 8'hF0, 8'h3C, 8'hCF};
    tbl[4] = '{OP_AND,  8'hFF, 8'h00, 8'h00};
    tbl[5] = '{OP_OR,   8'h00, 8'h00, 8'h00};
    tbl[6] = '{OP_XOR,  8'hFF, 8'hFF, 8'h00};
    tbl[7] = '{OP_NAND, 8'h00, 8'h00, 8'hFF};
    sat_exp = '{1, 2, 3, 3, 3};

    rst_n = 1'b0;
    hold_en = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = OP_AND;
    bus.a = 8'h00;
    bus.b = 8'h00;
    sbus.in_valid = 1'b0;
    sbus.out_ready = 1'b0;
    sbus.op = OP_AND;
    sbus.a = 8'h00;
    sbus.b = 8'h00;

    // combinational table, applied while reset is held
    for (int i = 0; i < 8; i++) begin
      bus.op = tbl[i].op;
      bus.a = tbl[i].a;
      bus.b = tbl[i].b;
      #1;
      chk("tbl_ycomb", 32'(y_comb), 32'(tbl[i].y));
    end
    chk("rst_yff", 32'(bus.y_ff), 32'h0);
    chk("rst_ovalid", 32'(bus.out_valid), 32'h0);
    chk("rst_hold", 32'(y_hold), 32'h0);
    chk("rst_cnt", 32'(res_cnt), 32'h0);
    chk("rst_iready", 32'(bus.in_ready), 32'h1);
    #2;
    rst_n = 1'b1;
    bus.op = OP_AND;
    bus.a = 8'h00;
    bus.b = 8'h00;
    cycle();

    // single XOR transfer, latency DEPTH
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = OP_XOR;
    bus.a = 8'hF0;
    bus.b = 8'h3C;
    #1;
    chk("xor_ycomb", 32'(y_comb), 32'hCC);
    cycle();
    bus.in_valid = 1'b0;
    chk("lat1_valid", 32'(bus.out_valid), 32'h0);
    cycle();
    chk("lat2_valid", 32'(bus.out_valid), 32'h1);
    chk("lat2_yff", 32'(bus.y_ff), 32'hCC);
    cycle();
    chk("cnt_one", 32'(res_cnt), 32'h1);

    // stall with full pipe, then simultaneous in/out
    got.delete();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = OP_AND;
    bus.a = 8'hFF;
    bus.b = 8'h01;
    cycle();
    bus.b = 8'h02;
    cycle();
    bus.b = 8'h03;
    #1;
    chk("full_iready", 32'(bus.in_ready), 32'h0);
    cycle();
    chk("stall_yff", 32'(bus.y_ff), 32'h01);
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    repeat (4) cycle();
    chk("order_cnt", 32'(got.size()), 32'd3);
    seq = 24'hFFFFFF;
    if (got.size() == 3) seq = {got[0], got[1], got[2]};
    chk("order_seq", 32'(seq), 32'h010203);

    // hold register keeps its value with hold_en low
    hold_en = 1'b1;
    bus.op = OP_XOR;
    bus.a = 8'hF0;
    bus.b = 8'hAA;
    cycle();
    hold_en = 1'b0;
    bus.a = 8'h12;
    bus.b = 8'h34;
    cycle();
    cycle();
    chk("hold_5a", 32'(y_hold), 32'h5A);

    // asynchronous reset pulse with two results in flight
    got.delete();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = OP_OR;
    bus.a = 8'h11;
    bus.b = 8'h22;
    cycle();
    bus.a = 8'h44;
    cycle();
    bus.in_valid = 1'b0;
    chk("pre_rst_ov", 32'(bus.out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(bus.out_valid), 32'h0);
    chk("arst_cnt", 32'(res_cnt), 32'h0);
    chk("arst_hold", 32'(y_hold), 32'h0);
    chk("arst_iready", 32'(bus.in_ready), 32'h1);
    q.delete();
    m_cnt = 16'h0;
    m_hold = 8'h00;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (4) cycle();
    chk("flushed", 32'(got.size()), 32'd0);

    // saturating counter on the CNT_W=2 instance
    hold_en = 1'b1;
    sbus.out_ready = 1'b1;
    sbus.op = OP_AND;
    sbus.a = 8'h01;
    sbus.b = 8'h01;
    dlv = 0;
    for (int i = 0; i < 20 && dlv < 5; i++) begin
      sbus.in_valid = (i < 5);
      sov = sbus.out_valid;
      if (sov) chk("sat_yff", 32'(sbus.y_ff), 32'h1);
      cycle();
      if (sov) begin
        dlv++;
        chk("sat_cnt", 32'(s_cnt), 32'(sat_exp[dlv-1]));
      end
    end
    sbus.in_valid = 1'b0;
    chk("sat_done", 32'(dlv), 32'd5);
    chk("sat_hold", 32'(s_hold), 32'h1);
    chk("sat_ycomb", 32'(s_ycomb), 32'h1);

    // random stream against the model
    repeat (400) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.op = op_e'(2'($urandom_range(0, 3)));
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      hold_en = 1'($urandom_range(0, 1));
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cycle();
    chk("drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
